// File: rtl/z16_pkg.sv
// Shared definitions for the Z16 register-file write path.
//   Z16_ADDR_W : register address width (16 registers)
//   Z16_DATA_W : register data width
//   pri_e      : write-port arbiter priority state
package z16_pkg;

  localparam int Z16_ADDR_W = 4;
  localparam int Z16_DATA_W = 16;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_e;

endpackage

// File: rtl/z16_rf_scoreboard.sv
// Pending-write bitmap for read-after-write hazard detection.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   set_en, set_addr   : decode issued a writer of register set_addr
//   clr_en, clr_addr   : register clr_addr is being written this cycle
//   busy               : bit n = register n has an outstanding write
module z16_rf_scoreboard #(
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  output logic [(1<<ADDR_W)-1:0] busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  assign set_mask = set_en ? (NREG'(1) << set_addr) : '0;
  assign clr_mask = clr_en ? (NREG'(1) << clr_addr) : '0;

  // Set is applied after clear: a new issue to a register committing this
  // cycle is still outstanding.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/z16_rf_write_arbiter.sv
// Arbitrates the register file's single write port between the ALU result
// path and the memory-load path. ALU has fixed priority; a starvation
// counter hands priority to the load path after STARVE_LIMIT lost cycles.
// Also tracks pending writes so decode can stall on RAW hazards.
// Ports:
//   i_clk, i_rst                   : clock, asynchronous active-high reset
//   i_alu_valid/addr/data, o_alu_ready : ALU writeback request handshake
//   i_mem_valid/addr/data, o_mem_ready : load writeback request handshake
//   i_issue_valid, i_issue_addr    : decode issued a register writer
//   o_rd_wen/addr/data             : registered register-file write port
//   o_busy                         : pending-write bitmap
module z16_rf_write_arbiter
  import z16_pkg::*;
#(
  parameter int ADDR_W       = Z16_ADDR_W,
  parameter int DATA_W       = Z16_DATA_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_alu_valid,
  input  logic [ADDR_W-1:0]      i_alu_addr,
  input  logic [DATA_W-1:0]      i_alu_data,
  output logic                   o_alu_ready,
  input  logic                   i_mem_valid,
  input  logic [ADDR_W-1:0]      i_mem_addr,
  input  logic [DATA_W-1:0]      i_mem_data,
  output logic                   o_mem_ready,
  input  logic                   i_issue_valid,
  input  logic [ADDR_W-1:0]      i_issue_addr,
  output logic                   o_rd_wen,
  output logic [ADDR_W-1:0]      o_rd_addr,
  output logic [DATA_W-1:0]      o_rd_data,
  output logic [(1<<ADDR_W)-1:0] o_busy
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  pri_e       state, state_next;
  logic [2:0] starve_cnt, starve_next;
  logic       alu_grant, mem_grant;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    alu_grant   = 1'b0;
    mem_grant   = 1'b0;
    state_next  = state;
    starve_next = starve_cnt;

    // Grants are suppressed while reset is held so nothing handshakes.
    if (!i_rst) begin
      case (state)
        PRI_ALU: begin
          if (i_alu_valid)      alu_grant = 1'b1;
          else if (i_mem_valid) mem_grant = 1'b1;
        end
        PRI_MEM: begin
          if (i_mem_valid)      mem_grant = 1'b1;
          else if (i_alu_valid) alu_grant = 1'b1;
        end
        default: ;
      endcase
    end

    // Count consecutive lost cycles of a waiting load, saturating at LIMIT.
    if (i_mem_valid && !mem_grant) begin
      if (starve_cnt != LIMIT) starve_next = starve_cnt + 3'd1;
    end else begin
      starve_next = '0;
    end

    // Switch on the losing edge that brings the count to LIMIT, so the load
    // wins on its (LIMIT+1)th waiting cycle.
    if (state == PRI_ALU && i_mem_valid && !mem_grant && starve_next == LIMIT)
      state_next = PRI_MEM;
    else if (state == PRI_MEM && mem_grant)
      state_next = PRI_ALU;
  end

  assign o_alu_ready = alu_grant;
  assign o_mem_ready = mem_grant;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= PRI_ALU;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Write-port register: address/data hold their last value when idle.
  // NOTE: the data register is reset along with the control flops because
  // the write port must read back as all-zero after reset, not X.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_wen  <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wen <= alu_grant | mem_grant;
      if (alu_grant) begin
        o_rd_addr <= i_alu_addr;
        o_rd_data <= i_alu_data;
      end else if (mem_grant) begin
        o_rd_addr <= i_mem_addr;
        o_rd_data <= i_mem_data;
      end
    end
  end

  z16_rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (i_clk),
    .rst      (i_rst),
    .set_en   (i_issue_valid),
    .set_addr (i_issue_addr),
    .clr_en   (o_rd_wen),
    .clr_addr (o_rd_addr),
    .busy     (o_busy)
  );

endmodule
